// File: rtl/seg7_pkg.sv
// +-----------------------------------------------------------------------+
// | seg7_pkg : shared segment codes, FSM state type, double-dabble step   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One shift-and-add-3 iteration on a two-digit BCD value, shifting bit_in in at the LSB.
  function automatic logic [7:0] dd_step(input logic [7:0] bcd, input logic bit_in);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = bcd[3:0];
    hi = bcd[7:4];
    if (lo >= 4'd5) lo = lo + 4'd3;
    if (hi >= 4'd5) hi = hi + 4'd3;
    return {hi[2:0], lo, bit_in};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dec7seg.sv
// +-----------------------------------------------------------------------+
// | dec7seg : BCD digit to active-low gfedcba seven-segment pattern       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module dec7seg
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/signed_result_display.sv
// +-----------------------------------------------------------------------+
// | signed_result_display : signed W-bit result to sign/tens/units 7-seg |
// | Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit.              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module signed_result_display
  import seg7_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_value,
  output logic         in_ready,
  output logic         out_valid,
  output logic [6:0]   hex_units,
  output logic [6:0]   hex_tens,
  output logic [6:0]   hex_sign
);

  localparam logic [2:0]   LAST_ITER = 3'(W - 1);
  localparam logic [W-1:0] ONE_W     = {{(W-1){1'b0}}, 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0]   TENS_RST  = SEG_BLANK;
`else
  localparam logic [6:0]   TENS_RST  = SEG_ZERO;
`endif

  state_t       state_q, state_d;
  logic         sign_q, sign_d;
  logic [W-1:0] mag_q, mag_d;
  logic [7:0]   bcd_q, bcd_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [6:0]   hex_units_q, hex_units_d;
  logic [6:0]   hex_tens_q, hex_tens_d;
  logic [6:0]   hex_sign_q, hex_sign_d;

  logic [7:0]   bcd_step;
  logic [6:0]   units_seg;
  logic [6:0]   tens_seg;
  logic [6:0]   tens_shown;

  assign bcd_step = dd_step(bcd_q, mag_q[W-1]);

  // Decoders look at the post-iteration value so the final edge can load the displays.
  dec7seg u_dec_units (
    .digit (bcd_step[3:0]),
    .seg   (units_seg)
  );

  dec7seg u_dec_tens (
    .digit (bcd_step[7:4]),
    .seg   (tens_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign tens_shown = (bcd_step[7:4] == 4'd0) ? SEG_BLANK : tens_seg;
`else
  assign tens_shown = tens_seg;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign hex_units = hex_units_q;
  assign hex_tens  = hex_tens_q;
  assign hex_sign  = hex_sign_q;

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    hex_units_d = hex_units_q;
    hex_tens_d  = hex_tens_q;
    hex_sign_d  = hex_sign_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CONV;
          sign_d  = in_value[W-1];
          // Most-negative input maps to 2^(W-1), which still fits unsigned in W bits.
          mag_d   = in_value[W-1] ? ((~in_value) + ONE_W) : in_value;
          bcd_d   = 8'd0;
          cnt_d   = 3'd0;
        end
      end
      ST_CONV: begin
        bcd_d = bcd_step;
        mag_d = {mag_q[W-2:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_ITER) begin
          state_d     = ST_DONE;
          hex_units_d = units_seg;
          hex_tens_d  = tens_shown;
          hex_sign_d  = sign_q ? SEG_MINUS : SEG_BLANK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= 8'd0;
      cnt_q       <= 3'd0;
      hex_units_q <= SEG_ZERO;
      hex_tens_q  <= TENS_RST;
      hex_sign_q  <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      hex_units_q <= hex_units_d;
      hex_tens_q  <= hex_tens_d;
      hex_sign_q  <= hex_sign_d;
    end
  end

endmodule

`default_nettype wire
